// File: rtl/jtag_dr_master.sv
// JTAG initiator: resets the TAP, loads USER_IR, then shifts a DR_LENGTH-bit DR while capturing TDO.
// Optional JTAG_DR_MASTER_IR_CACHE_EN: after the first completed transaction, skip TLR/IR and start at SEL_DR2.
module jtag_dr_master #(
    parameter int unsigned IR_LENGTH = 6,
    parameter logic [IR_LENGTH-1:0] USER_IR = 6'h22,
    parameter int unsigned DR_LENGTH = 4,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DR_LENGTH-1:0] wr_data,
    output logic [DR_LENGTH-1:0] rd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 tck,
    output logic                 tms,
    output logic                 tdi,
    input  logic                 tdo
);

    localparam int unsigned LEN_MAX = (IR_LENGTH > DR_LENGTH) ?
                                      ((IR_LENGTH > 5) ? IR_LENGTH : 5) :
                                      ((DR_LENGTH > 5) ? DR_LENGTH : 5);
    localparam int unsigned CNT_W = $clog2(LEN_MAX);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        IDLE, TLR, RTI, SEL_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR,
        UPD_IR, SEL_DR2, CAP_DR, SH_DR, EX1_DR, UPD_DR
    } state_t;

    state_t               state, state_nxt, start_state;
    logic [CNT_W-1:0]     bit_cnt, cnt_nxt, last_cnt;
    logic [DIV_W-1:0]     div_cnt;
    logic [IR_LENGTH-1:0] ir_sr, ir_sr_nxt;
    logic [DR_LENGTH-1:0] dr_sr, dr_sr_nxt, cap_sr;
    logic                 div_tick, tck_rise, tck_fall, accept, finish;
    logic                 tms_nxt, tdi_nxt;

    assign div_tick = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign tck_rise = busy && !tck && div_tick;
    assign tck_fall = busy && tck && div_tick;
    assign accept   = (state == IDLE) && start && !done;

`ifdef JTAG_DR_MASTER_IR_CACHE_EN
    logic ir_loaded;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         ir_loaded <= 1'b0;
        else if (finish) ir_loaded <= 1'b1;
    end

    assign start_state = ir_loaded ? SEL_DR2 : TLR;
`else
    assign start_state = TLR;
`endif

    // Capture states take two TCKs: one into Capture, one on into Shift.
    always_comb begin
        case (state)
            TLR:            last_cnt = CNT_W'(4);
            CAP_IR, CAP_DR: last_cnt = CNT_W'(1);
            SH_IR:          last_cnt = CNT_W'(IR_LENGTH - 1);
            SH_DR:          last_cnt = CNT_W'(DR_LENGTH - 1);
            default:        last_cnt = CNT_W'(0);
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= cnt_nxt;
        end
    end

    // Next state: advance one TCK per falling edge
    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        if (state == IDLE) begin
            if (accept) begin
                state_nxt = start_state;
                cnt_nxt   = '0;
            end
        end else if (tck_fall) begin
            if (bit_cnt == last_cnt) begin
                cnt_nxt = '0;
                case (state)
                    TLR:     state_nxt = RTI;
                    RTI:     state_nxt = SEL_DR;
                    SEL_DR:  state_nxt = SEL_IR;
                    SEL_IR:  state_nxt = CAP_IR;
                    CAP_IR:  state_nxt = SH_IR;
                    SH_IR:   state_nxt = EX1_IR;
                    EX1_IR:  state_nxt = UPD_IR;
                    UPD_IR:  state_nxt = SEL_DR2;
                    SEL_DR2: state_nxt = CAP_DR;
                    CAP_DR:  state_nxt = SH_DR;
                    SH_DR:   state_nxt = EX1_DR;
                    EX1_DR:  state_nxt = UPD_DR;
                    default: state_nxt = IDLE;
                endcase
            end else begin
                cnt_nxt = bit_cnt + CNT_W'(1);
            end
        end
    end

    // Output decode: TMS/TDI for the bit about to be driven
    always_comb begin
        ir_sr_nxt = ir_sr;
        dr_sr_nxt = dr_sr;
        tms_nxt   = 1'b0;
        tdi_nxt   = 1'b0;
        finish    = tck_fall && (state == UPD_DR);
        if (accept) begin
            ir_sr_nxt = USER_IR;
            dr_sr_nxt = wr_data;
        end else if (tck_fall && state == SH_IR) begin
            ir_sr_nxt = ir_sr >> 1;
        end else if (tck_fall && state == SH_DR) begin
            dr_sr_nxt = dr_sr << 1;
        end
        case (state_nxt)
            TLR, SEL_DR, SEL_IR, EX1_IR, SEL_DR2, EX1_DR: tms_nxt = 1'b1;
            SH_IR: begin
                tms_nxt = (cnt_nxt == CNT_W'(IR_LENGTH - 1));
                tdi_nxt = ir_sr_nxt[0];
            end
            SH_DR: begin
                tms_nxt = (cnt_nxt == CNT_W'(DR_LENGTH - 1));
                tdi_nxt = dr_sr_nxt[DR_LENGTH-1];
            end
            default: tms_nxt = 1'b0;
        endcase
    end

    // Registered JTAG pins, divider, shifters and handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tck     <= 1'b0;
            tms     <= 1'b1;
            tdi     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_data <= '0;
            div_cnt <= '0;
            ir_sr   <= '0;
            dr_sr   <= '0;
            cap_sr  <= '0;
        end else begin
            done  <= finish;
            ir_sr <= ir_sr_nxt;
            dr_sr <= dr_sr_nxt;
            if (accept)      busy <= 1'b1;
            else if (finish) busy <= 1'b0;
            if (busy) begin
                if (div_tick) begin
                    div_cnt <= '0;
                    tck     <= !tck;
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
            if (accept || tck_fall) begin
                tms <= tms_nxt;
                tdi <= tdi_nxt;
            end
            if (tck_rise && state == SH_DR) cap_sr <= {cap_sr[DR_LENGTH-2:0], tdo};
            if (finish) rd_data <= cap_sr;
        end
    end

endmodule
